// File: rtl/serial_bit_source.sv
// Parallel-to-serial word feeder for single-bit sequence detectors.
// Accepts a word over valid/ready and holds each bit on w for BIT_PERIOD clocks.
module serial_bit_source #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_PERIOD = 1,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] din,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              w,
    output logic              w_valid,
    output logic              bit_strobe,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TICK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(BIT_PERIOD - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
    logic                last_cyc;
    logic                accept;
    logic                w_n, active_n, strobe_n, done_n;

    // Bit currently presented at the output end of the shift register
    function automatic logic head_bit(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? s[DATA_W-1] : s[0];
    endfunction

    assign last_cyc   = (state == SHIFT) && (bit_cnt == LAST_BIT) && (tick_cnt == LAST_TICK);
    assign load_ready = !Reset && ((state == IDLE) || last_cyc);
    assign accept     = load_valid && load_ready;

    // Next-state and next-output computation; outputs are registered from these
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        tick_cnt_n = tick_cnt;

        if (accept) begin
            state_n    = SHIFT;
            shreg_n    = din;
            bit_cnt_n  = '0;
            tick_cnt_n = '0;
        end else if (state == SHIFT) begin
            if (last_cyc) begin
                state_n = IDLE;
            end else if (tick_cnt != LAST_TICK) begin
                tick_cnt_n = tick_cnt + TICK_W'(1);
            end else begin
                tick_cnt_n = '0;
                bit_cnt_n  = bit_cnt + BIT_W'(1);
                shreg_n    = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            end
        end

        active_n = (state_n == SHIFT);
        w_n      = active_n ? head_bit(shreg_n) : IDLE_LEVEL;
        strobe_n = active_n && (tick_cnt_n == '0);
        done_n   = active_n && (bit_cnt_n == LAST_BIT) && (tick_cnt_n == LAST_TICK);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tick_cnt   <= '0;
            w          <= IDLE_LEVEL;
            w_valid    <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            tick_cnt   <= tick_cnt_n;
            w          <= w_n;
            w_valid    <= active_n;
            bit_strobe <= strobe_n;
            busy       <= active_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: MSB/LSB order, bit stretching,
// back-to-back words, ignored loads, mid-word reset and a one-bit word.
module tb_serial_bit_source;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic [7:0] din;
    logic [0:0] din_d;
    logic lv_a, lv_b, lv_c, lv_d;
    logic rdy_a, w_a, wv_a, st_a, bsy_a, dn_a;
    logic rdy_b, w_b, wv_b, st_b, bsy_b, dn_b;
    logic rdy_c, w_c, wv_c, st_c, bsy_c, dn_c;
    logic rdy_d, w_d, wv_d, st_d, bsy_d, dn_d;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    serial_bit_source #(.DATA_W(8), .BIT_PERIOD(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .Clock(Clock), .Reset(Reset), .din(din), .load_valid(lv_a), .load_ready(rdy_a),
        .w(w_a), .w_valid(wv_a), .bit_strobe(st_a), .busy(bsy_a), .done(dn_a));

    serial_bit_source #(.DATA_W(8), .BIT_PERIOD(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .Clock(Clock), .Reset(Reset), .din(din), .load_valid(lv_b), .load_ready(rdy_b),
        .w(w_b), .w_valid(wv_b), .bit_strobe(st_b), .busy(bsy_b), .done(dn_b));

    serial_bit_source #(.DATA_W(8), .BIT_PERIOD(3), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
        .Clock(Clock), .Reset(Reset), .din(din), .load_valid(lv_c), .load_ready(rdy_c),
        .w(w_c), .w_valid(wv_c), .bit_strobe(st_c), .busy(bsy_c), .done(dn_c));

    serial_bit_source #(.DATA_W(1), .BIT_PERIOD(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_d (
        .Clock(Clock), .Reset(Reset), .din(din_d), .load_valid(lv_d), .load_ready(rdy_d),
        .w(w_d), .w_valid(wv_d), .bit_strobe(st_d), .busy(bsy_d), .done(dn_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [7:0]  e;
        logic [15:0] e16;
        logic [2:0]  hist;
        int          hits;

        Reset = 1'b1; din = '0; din_d = '0;
        lv_a = 0; lv_b = 0; lv_c = 0; lv_d = 0;
        tick(); tick();

        // Reset values
        check("rst_w_a", 32'(w_a), 0);
        check("rst_busy_a", 32'(bsy_a), 0);
        check("rst_rdy_a", 32'(rdy_a), 0);
        check("rst_done_a", 32'(dn_a), 0);
        check("rst_w_d_idle1", 32'(w_d), 1);
        Reset = 1'b0;
        #1;
        check("idle_rdy_a", 32'(rdy_a), 1);

        // 8'hB2: MSB-first on u_a, LSB-first on u_b
        e = 8'hB2; din = e; lv_a = 1; lv_b = 1;
        tick();
        lv_a = 0; lv_b = 0;
        for (int i = 0; i < 8; i++) begin
            check("t1_w_msb", 32'(w_a), 32'(e[7-i]));
            check("t1_done", 32'(dn_a), (i == 7) ? 1 : 0);
            check("t1_strobe", 32'(st_a), 1);
            check("t2_w_lsb", 32'(w_b), 32'(e[i]));
            check("t2_wvalid", 32'(wv_b), 1);
            tick();
        end
        check("t1_after_w", 32'(w_a), 0);
        check("t1_after_busy", 32'(bsy_a), 0);
        check("t1_after_done", 32'(dn_a), 0);
        check("t2_after_wvalid", 32'(wv_b), 0);

        // 8'h81 with each bit held 3 clocks
        e = 8'h81; din = e; lv_c = 1;
        tick();
        lv_c = 0;
        for (int c = 1; c <= 24; c++) begin
            check("t3_w", 32'(w_c), 32'(e[7 - (c-1)/3]));
            check("t3_strobe", 32'(st_c), (((c-1) % 3) == 0) ? 1 : 0);
            check("t3_done", 32'(dn_c), (c == 24) ? 1 : 0);
            check("t3_busy", 32'(bsy_c), 1);
            tick();
        end
        check("t3_after_busy", 32'(bsy_c), 0);
        check("t3_after_w", 32'(w_c), 0);

        // Back-to-back F0 then 0F with load_valid held
        e16 = 16'hF00F; din = 8'hF0; lv_a = 1;
        tick();
        din = 8'h0F;
        for (int c = 1; c <= 16; c++) begin
            if (c == 9) lv_a = 0;
            check("t4_w", 32'(w_a), 32'(e16[16-c]));
            check("t4_busy", 32'(bsy_a), 1);
            check("t4_done", 32'(dn_a), (c == 8 || c == 16) ? 1 : 0);
            if (c == 8) check("t4_rdy_last", 32'(rdy_a), 1);
            if (c == 7) check("t4_rdy_mid", 32'(rdy_a), 0);
            tick();
        end
        check("t4_after_busy", 32'(bsy_a), 0);

        // Load pulse mid-word is ignored; din change does not disturb the word
        e = 8'h3C; din = e; lv_a = 1;
        tick();
        lv_a = 0;
        for (int c = 1; c <= 8; c++) begin
            check("t5_w", 32'(w_a), 32'(e[8-c]));
            check("t5_done", 32'(dn_a), (c == 8) ? 1 : 0);
            if (c == 3) begin
                check("t5_rdy_busy", 32'(rdy_a), 0);
                din = 8'hFF; lv_a = 1;
            end
            if (c == 4) lv_a = 0;
            tick();
        end
        check("t5_after_busy", 32'(bsy_a), 0);
        check("t5_after_w", 32'(w_a), 0);

        // Reset in cycle 4 of 8'hAA aborts the word; 8'h55 follows cleanly
        din = 8'hAA; lv_a = 1;
        tick();
        lv_a = 0;
        tick(); tick(); tick();
        Reset = 1'b1;
        #1;
        check("t6_rst_w", 32'(w_a), 0);
        check("t6_rst_busy", 32'(bsy_a), 0);
        check("t6_rst_wvalid", 32'(wv_a), 0);
        check("t6_rst_done", 32'(dn_a), 0);
        check("t6_rst_strobe", 32'(st_a), 0);
        check("t6_rst_rdy", 32'(rdy_a), 0);
        tick();
        check("t6_hold_done", 32'(dn_a), 0);
        Reset = 1'b0;
        #1;
        check("t6_rdy_after", 32'(rdy_a), 1);
        e = 8'h55; din = e; lv_a = 1;
        tick();
        lv_a = 0;
        for (int c = 1; c <= 8; c++) begin
            check("t6_w", 32'(w_a), 32'(e[8-c]));
            check("t6_done", 32'(dn_a), (c == 8) ? 1 : 0);
            tick();
        end
        check("t6_after_busy", 32'(bsy_a), 0);

        // One-bit word: done on the first bit, idle level 1 afterwards
        din_d = 1'b0; lv_d = 1;
        tick();
        lv_d = 0;
        check("t8_w", 32'(w_d), 0);
        check("t8_done", 32'(dn_d), 1);
        check("t8_strobe", 32'(st_d), 1);
        check("t8_busy", 32'(bsy_d), 1);
        tick();
        check("t8_idle_w", 32'(w_d), 1);
        check("t8_idle_busy", 32'(bsy_d), 0);

        // Overlapping "101" detector on the serial stream of 8'hA5 (expect 2 hits)
        din = 8'hA5; lv_a = 1; hist = '0; hits = 0;
        tick();
        lv_a = 0;
        for (int c = 1; c <= 8; c++) begin
            hist = {hist[1:0], w_a};
            if (c >= 3 && hist == 3'b101) hits++;
            tick();
        end
        check("t7_det_hits", 32'(hits), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
